// File: rtl/vreg_load_packer.sv
// rtl/vreg_load_packer.sv - vector-load writeback engine
// Fetches LANES strided words from memory, packs them, and issues one vector register-file write.
module vreg_load_packer #(
    parameter int LANES   = 16,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W-1:0]         stride,
    input  logic [3:0]                dest_reg,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ready,
    input  logic                      mem_rvalid,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      rf_we,
    output logic                      rf_sel_v,
    output logic [3:0]                rf_wa,
    output logic [LANES*DATA_W-1:0]   rf_wd
);
    localparam int CNT_W  = $clog2(LANES + 1);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, stride_q;
    logic [3:0]                dest_q;
    logic [CNT_W-1:0]          issued_q, recv_q, outstanding;
    logic [DATA_W-1:0]         lane_q [LANES];
    logic                      accept, rx, last_rx;
    logic [LANE_W-1:0]         lane_idx;
    logic [LANES*DATA_W-1:0]   packed_d;
    logic                      we_q, done_q, sel_q;
    logic [3:0]                wa_q;
    logic [LANES*DATA_W-1:0]   wd_q;

    assign outstanding = issued_q - recv_q;

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        accept   = 1'b0;
        rx       = 1'b0;
        last_rx  = 1'b0;
        lane_idx = LANE_W'(LANES - 1 - int'(recv_q));
        packed_d = '0;

        if (state_q == S_FETCH) begin
            mem_req = (issued_q < CNT_W'(LANES)) && (outstanding < CNT_W'(MAX_OUT));
            // Responses with nothing in flight are stale and must not consume a lane.
            rx      = mem_rvalid && (outstanding != '0);
        end
        accept  = mem_req && mem_ready;
        last_rx = rx && (recv_q == CNT_W'(LANES - 1));

        // The final element lands in the same cycle the vector is captured for writeback.
        for (int i = 0; i < LANES; i++) begin
            if (rx && (lane_idx == LANE_W'(i)))
                packed_d[i*DATA_W +: DATA_W] = mem_rdata;
            else
                packed_d[i*DATA_W +: DATA_W] = lane_q[i];
        end

        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (last_rx) state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            stride_q <= '0;
            dest_q   <= '0;
            issued_q <= '0;
            recv_q   <= '0;
            for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            sel_q    <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
        end else begin
            we_q   <= last_rx;
            done_q <= last_rx;
            sel_q  <= last_rx;
            if (last_rx) begin
                wa_q <= dest_q;
                wd_q <= packed_d;
            end

            if (state_q == S_IDLE && start) begin
                addr_q   <= base_addr;
                stride_q <= stride;
                dest_q   <= dest_reg;
                issued_q <= '0;
                recv_q   <= '0;
            end else begin
                if (accept) begin
                    addr_q   <= addr_q + stride_q;
                    issued_q <= issued_q + CNT_W'(1);
                end
                if (rx) begin
                    lane_q[lane_idx] <= mem_rdata;
                    recv_q           <= recv_q + CNT_W'(1);
                end
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign mem_addr = addr_q;
    assign rf_we    = we_q;
    assign done     = done_q;
    assign rf_sel_v = sel_q;
    assign rf_wa    = wa_q;
    assign rf_wd    = wd_q;
endmodule
